rob_rollback_ctrl: RTL and testbench
====================================

Name: rob_rollback_ctrl

Overview:
- Sequences ROB mis-speculation recovery. Arbitrates BRU and LQ restart requests and picks the oldest.
- Issues the checkpoint restore command. On restore failure, or for any LQ restart, walks the ROB from tail-1 back to the restart boundary, driving the kill bus once per entry.
- Finishes with a one-cycle redirect: fetch PC, ROB tail restore, core control.
- Sits between the BRU/LQ and the ROB, dispatch unit, restore bus, kill bus and core control.

Parameters:
ROB_DEPTH, 16, ROB entry count; must be a power of 2
INDEX_W, 4, log2(ROB_DEPTH)

Ports:
CLK  in  1  clock
nRST  in  1  reset, synchronous, active-high (1 = reset)
rob_head_index  in  INDEX_W  current ROB head
rob_tail_index  in  INDEX_W  current ROB tail (next free)
rob_count  in  INDEX_W+1  valid ROB entries
BRU_restart_valid  in  1  branch mispredict
BRU_restart_ROB_index  in  INDEX_W  branch entry
BRU_restart_PC  in  32  correct PC
BRU_restart_safe_column  in  2  checkpoint column
LQ_restart_valid  in  1  load-ordering violation
LQ_restart_ROB_index  in  INDEX_W  load entry
LQ_restart_PC  in  32  load PC
restore_checkpoint_valid  out  1  restore command
restore_checkpoint_speculate_failed  out  1  always 1 when valid
restore_checkpoint_ROB_index  out  INDEX_W  branch entry
restore_checkpoint_safe_column  out  2  column
restore_checkpoint_success  in  1  same-cycle ack
kill_read_index  out  INDEX_W  ROB read address (combinational read)
kill_read_writes_reg  in  1  entry has a destination register
kill_read_arch_reg_tag  in  5  entry arch reg
kill_read_safe_phys_reg_tag  in  6  entry old mapping
kill_read_speculated_phys_reg_tag  in  6  entry new mapping
kill_bus_valid  out  1  kill broadcast
kill_bus_ROB_index  out  INDEX_W
kill_bus_arch_reg_tag  out  5
kill_bus_safe_phys_reg_tag  out  6
kill_bus_speculated_phys_reg_tag  out  6
rob_tail_restore_valid  out  1  ROB sets tail
rob_tail_restore_index  out  INDEX_W  new tail
fetch_restart_valid  out  1
fetch_restart_PC  out  32
core_control_restore_flush  out  1
core_control_kill_stall  out  1
busy  out  1

Behaviour:
- Reset: FSM=IDLE; all outputs 0; latched request cleared. Reset mid-walk abandons the walk with no redirect.
- Age: age(x) = {1'b0, (x - rob_head_index) mod ROB_DEPTH}, INDEX_W+1 bits.
- Boundary (oldest entry to squash):
  - BRU: idx+1, boundary age = age(idx)+1; the branch survives.
  - LQ: idx, boundary age = age(idx); the load is re-executed.
- Arbitration, both requests valid in the same cycle: the smaller boundary age wins. On a tie, BRU wins.
- IDLE, request accepted:
  - Latch boundary index, PC, type and column.
  - Pulse core_control_restore_flush for 1 cycle (the accept cycle).
  - Next state: RESTORE if BRU, else KILL.
- RESTORE (1 cycle):
  - Drive restore_checkpoint_valid=1, speculate_failed=1, with the latched index and column.
  - success=1: go to REDIRECT with no walk.
  - success=0: go to KILL.
- KILL:
  - Walk pointer starts at rob_tail_index-1, sampled on entry.
  - Each cycle: kill_read_index = ptr. kill_bus_valid = kill_read_writes_reg. Kill fields come from the read port, and kill_bus_ROB_index = ptr.
  - ptr decrements mod ROB_DEPTH. After the cycle where ptr == boundary index, go to REDIRECT.
  - If boundary age >= rob_count at entry, skip straight to REDIRECT (0 kill cycles).
- REDIRECT (1 cycle):
  - fetch_restart_valid=1 with the latched PC.
  - rob_tail_restore_valid=1 with rob_tail_restore_index = boundary index.
  - Then return to IDLE.
- core_control_kill_stall = 1 in RESTORE, KILL and REDIRECT. busy = 1 whenever the state is not IDLE.
- New request while busy:
  - Boundary age (current head) strictly less than the latched boundary age: replaces the latched boundary, PC, type and column.
  - In RESTORE: this cycle completes normally, then go to KILL.
  - In KILL: the walk continues down to the new boundary.
  - In REDIRECT: re-enter KILL from the current tail-1.
  - Otherwise the request is dropped; it is younger and will be squashed.
- Retirement continues during recovery. Walk termination compares indices only; no age recompute is needed.

Decomposition:
- Into core_types_pkg:
  - rob_rollback_state_t enum {IDLE, RESTORE, KILL, REDIRECT}
  - restart_req_t struct {valid, is_bru, index, pc, column}
  - ROB_index_t is reused.
- Sub-module rob_age_compare: computes two boundary ages against head and emits the older select. It is used by both the arbiter and the preemption check.

Test Plan:
- Reset: nRST=1 for 2 cycles mid-KILL -> all outputs 0 next cycle, IDLE, no fetch_restart_valid.
- BRU, head=2, tail=8, idx=4, success=1 -> flush pulse, restore 1 cycle, then REDIRECT with tail_restore=5; 0 kill cycles.
- BRU, idx=4, tail=8, success=0 -> kill indices 7,6,5 in 3 consecutive cycles, then REDIRECT with tail_restore=5.
- LQ, head=14, tail=2, idx=15 (wrap) -> kill indices 1,0,15; tail_restore=15; fetch_restart_PC=LQ PC.
- Simultaneous requests, head=0: BRU idx=6 and LQ idx=3 -> LQ wins with boundary 3. Repeat with LQ idx=7 and BRU idx=6 -> boundaries tie, BRU wins.
- Preemption: during KILL toward boundary 6 (head=0), LQ idx=2 arrives -> walk extends through index 2; tail_restore=2; PC=LQ PC.
- Entries with kill_read_writes_reg=0 -> kill_bus_valid=0 in that cycle, but the walk cycle is still consumed.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core types used by the ROB rollback controller and its helpers.
package core_types_pkg;

    localparam int CORE_ROB_DEPTH = 16;
    localparam int CORE_INDEX_W   = 4;

    typedef logic [CORE_INDEX_W-1:0] ROB_index_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESTORE  = 2'd1,
        KILL     = 2'd2,
        REDIRECT = 2'd3
    } rob_rollback_state_t;

    // index holds the requesting entry (branch or load), not the boundary.
    typedef struct packed {
        logic        valid;
        logic        is_bru;
        ROB_index_t  index;
        logic [31:0] pc;
        logic [1:0]  column;
    } restart_req_t;

    // Oldest entry to squash: a branch survives, a load is re-executed.
    function automatic ROB_index_t boundary_index(input ROB_index_t idx, input logic is_bru);
        return idx + ROB_index_t'(is_bru);
    endfunction

endpackage

// File: rtl/rob_age_compare.sv
// Boundary-age comparator: ages two restart requests relative to the ROB head
// and reports whether request b squashes from an older point than request a.
module rob_age_compare
    import core_types_pkg::*;
#(
    parameter int INDEX_W = CORE_INDEX_W
) (
    input  logic [INDEX_W-1:0] head,
    input  logic [INDEX_W-1:0] a_index,
    input  logic               a_inc,
    input  logic [INDEX_W-1:0] b_index,
    input  logic               b_inc,
    output logic [INDEX_W:0]   a_age,
    output logic [INDEX_W:0]   b_age,
    output logic               b_older
);

    // Extra age bit keeps a branch at the youngest slot (age 15 + 1) ordered correctly.
    always_comb begin
        a_age   = {1'b0, a_index - head} + {{INDEX_W{1'b0}}, a_inc};
        b_age   = {1'b0, b_index - head} + {{INDEX_W{1'b0}}, b_inc};
        b_older = (b_age < a_age);
    end

endmodule

// File: rtl/rob_rollback_ctrl.sv
// ROB mis-speculation recovery sequencer: arbitrates BRU/LQ restarts, issues the
// checkpoint restore, walks the ROB killing younger entries, then redirects fetch.
module rob_rollback_ctrl
    import core_types_pkg::*;
#(
    parameter int ROB_DEPTH = CORE_ROB_DEPTH,
    parameter int INDEX_W   = CORE_INDEX_W
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [INDEX_W-1:0] rob_head_index,
    input  logic [INDEX_W-1:0] rob_tail_index,
    input  logic [INDEX_W:0]   rob_count,
    input  logic               BRU_restart_valid,
    input  logic [INDEX_W-1:0] BRU_restart_ROB_index,
    input  logic [31:0]        BRU_restart_PC,
    input  logic [1:0]         BRU_restart_safe_column,
    input  logic               LQ_restart_valid,
    input  logic [INDEX_W-1:0] LQ_restart_ROB_index,
    input  logic [31:0]        LQ_restart_PC,
    output logic               restore_checkpoint_valid,
    output logic               restore_checkpoint_speculate_failed,
    output logic [INDEX_W-1:0] restore_checkpoint_ROB_index,
    output logic [1:0]         restore_checkpoint_safe_column,
    input  logic               restore_checkpoint_success,
    output logic [INDEX_W-1:0] kill_read_index,
    input  logic               kill_read_writes_reg,
    input  logic [4:0]         kill_read_arch_reg_tag,
    input  logic [5:0]         kill_read_safe_phys_reg_tag,
    input  logic [5:0]         kill_read_speculated_phys_reg_tag,
    output logic               kill_bus_valid,
    output logic [INDEX_W-1:0] kill_bus_ROB_index,
    output logic [4:0]         kill_bus_arch_reg_tag,
    output logic [5:0]         kill_bus_safe_phys_reg_tag,
    output logic [5:0]         kill_bus_speculated_phys_reg_tag,
    output logic               rob_tail_restore_valid,
    output logic [INDEX_W-1:0] rob_tail_restore_index,
    output logic               fetch_restart_valid,
    output logic [31:0]        fetch_restart_PC,
    output logic               core_control_restore_flush,
    output logic               core_control_kill_stall,
    output logic               busy
);

    rob_rollback_state_t state_q, state_d;
    restart_req_t        req_q, req_d, in_req;
    logic [INDEX_W-1:0]  ptr_q, ptr_d;
    logic [INDEX_W-1:0]  req_bidx;
    logic [INDEX_W:0]    arb_bru_age, arb_lq_age, new_age, held_age, unused_pre_new_age;
    logic                arb_lq_older, pre_new_older, lq_wins;
    logic                preempt, take_new, enter_kill;

    function automatic logic [INDEX_W-1:0] index_dec(input logic [INDEX_W-1:0] x);
        return INDEX_W'((32'(x) + 32'(ROB_DEPTH) - 32'd1) % 32'(ROB_DEPTH));
    endfunction

    rob_age_compare #(.INDEX_W(INDEX_W)) u_arb_age (
        .head    (rob_head_index),
        .a_index (BRU_restart_ROB_index),
        .a_inc   (1'b1),
        .b_index (LQ_restart_ROB_index),
        .b_inc   (1'b0),
        .a_age   (arb_bru_age),
        .b_age   (arb_lq_age),
        .b_older (arb_lq_older)
    );

    // Pick the incoming request with the oldest boundary; ties go to the branch.
    always_comb begin
        lq_wins       = LQ_restart_valid && (!BRU_restart_valid || arb_lq_older);
        in_req.valid  = BRU_restart_valid || LQ_restart_valid;
        in_req.is_bru = !lq_wins;
        in_req.index  = lq_wins ? LQ_restart_ROB_index : BRU_restart_ROB_index;
        in_req.pc     = lq_wins ? LQ_restart_PC : BRU_restart_PC;
        in_req.column = lq_wins ? 2'b00 : BRU_restart_safe_column;
        new_age       = lq_wins ? arb_lq_age : arb_bru_age;
    end

    rob_age_compare #(.INDEX_W(INDEX_W)) u_pre_age (
        .head    (rob_head_index),
        .a_index (req_q.index),
        .a_inc   (req_q.is_bru),
        .b_index (in_req.index),
        .b_inc   (in_req.is_bru),
        .a_age   (held_age),
        .b_age   (unused_pre_new_age),
        .b_older (pre_new_older)
    );

    // Recovery sequencing; an older request arriving mid-recovery replaces the held one.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ptr_d      = ptr_q;
        enter_kill = 1'b0;
        preempt    = (state_q != IDLE) && in_req.valid && pre_new_older;
        take_new   = preempt || ((state_q == IDLE) && in_req.valid);
        if (take_new) begin
            req_d = in_req;
        end
        req_bidx = take_new ? boundary_index(in_req.index, in_req.is_bru)
                            : boundary_index(req_q.index, req_q.is_bru);
        case (state_q)
            IDLE: begin
                if (in_req.valid) begin
                    if (in_req.is_bru) begin
                        state_d = RESTORE;
                    end else begin
                        enter_kill = 1'b1;
                    end
                end
            end
            RESTORE: begin
                if (preempt || !restore_checkpoint_success) begin
                    enter_kill = 1'b1;
                end else begin
                    state_d = REDIRECT;
                end
            end
            KILL: begin
                ptr_d = index_dec(ptr_q);
                if (ptr_q == req_bidx) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (preempt) begin
                    enter_kill = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Walk from the youngest entry; nothing to kill if the boundary lies past the tail.
        if (enter_kill) begin
            ptr_d   = index_dec(rob_tail_index);
            state_d = ((take_new ? new_age : held_age) >= rob_count) ? REDIRECT : KILL;
        end
    end

    // State, held request and walk pointer registers.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q <= IDLE;
            req_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output decode from the current state; kill fields pass straight from the ROB read port.
    always_comb begin
        restore_checkpoint_valid            = 1'b0;
        restore_checkpoint_speculate_failed = 1'b0;
        restore_checkpoint_ROB_index        = '0;
        restore_checkpoint_safe_column      = 2'b00;
        kill_read_index                     = '0;
        kill_bus_valid                      = 1'b0;
        kill_bus_ROB_index                  = '0;
        kill_bus_arch_reg_tag               = '0;
        kill_bus_safe_phys_reg_tag          = '0;
        kill_bus_speculated_phys_reg_tag    = '0;
        rob_tail_restore_valid              = 1'b0;
        rob_tail_restore_index              = '0;
        fetch_restart_valid                 = 1'b0;
        fetch_restart_PC                    = '0;
        core_control_restore_flush          = !nRST && (state_q == IDLE) && in_req.valid;
        core_control_kill_stall             = (state_q != IDLE);
        busy                                = (state_q != IDLE);
        case (state_q)
            RESTORE: begin
                restore_checkpoint_valid            = req_q.valid;
                restore_checkpoint_speculate_failed = req_q.valid;
                restore_checkpoint_ROB_index        = req_q.index;
                restore_checkpoint_safe_column      = req_q.column;
            end
            KILL: begin
                kill_read_index                  = ptr_q;
                kill_bus_valid                   = kill_read_writes_reg;
                kill_bus_ROB_index               = ptr_q;
                kill_bus_arch_reg_tag            = kill_read_arch_reg_tag;
                kill_bus_safe_phys_reg_tag       = kill_read_safe_phys_reg_tag;
                kill_bus_speculated_phys_reg_tag = kill_read_speculated_phys_reg_tag;
            end
            REDIRECT: begin
                fetch_restart_valid    = req_q.valid;
                fetch_restart_PC       = req_q.pc;
                rob_tail_restore_valid = req_q.valid;
                rob_tail_restore_index = boundary_index(req_q.index, req_q.is_bru);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rob_rollback_ctrl.sv
// Self-checking bench for rob_rollback_ctrl: directed vector table, hand-written
// preemption and reset sequences, and randomized transactions against a model.
module tb_rob_rollback_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  rob_head_index, rob_tail_index;
    logic [4:0]  rob_count;
    logic        BRU_restart_valid;
    logic [3:0]  BRU_restart_ROB_index;
    logic [31:0] BRU_restart_PC;
    logic [1:0]  BRU_restart_safe_column;
    logic        LQ_restart_valid;
    logic [3:0]  LQ_restart_ROB_index;
    logic [31:0] LQ_restart_PC;
    logic        restore_checkpoint_valid, restore_checkpoint_speculate_failed;
    logic [3:0]  restore_checkpoint_ROB_index;
    logic [1:0]  restore_checkpoint_safe_column;
    logic        restore_checkpoint_success;
    logic [3:0]  kill_read_index;
    logic        kill_read_writes_reg;
    logic [4:0]  kill_read_arch_reg_tag;
    logic [5:0]  kill_read_safe_phys_reg_tag, kill_read_speculated_phys_reg_tag;
    logic        kill_bus_valid;
    logic [3:0]  kill_bus_ROB_index;
    logic [4:0]  kill_bus_arch_reg_tag;
    logic [5:0]  kill_bus_safe_phys_reg_tag, kill_bus_speculated_phys_reg_tag;
    logic        rob_tail_restore_valid;
    logic [3:0]  rob_tail_restore_index;
    logic        fetch_restart_valid;
    logic [31:0] fetch_restart_PC;
    logic        core_control_restore_flush, core_control_kill_stall, busy;

    // ROB contents seen through the combinational read port
    logic       rob_wr   [16];
    logic [4:0] rob_arch [16];
    logic [5:0] rob_safe [16];
    logic [5:0] rob_spec [16];

    assign kill_read_writes_reg              = rob_wr[kill_read_index];
    assign kill_read_arch_reg_tag            = rob_arch[kill_read_index];
    assign kill_read_safe_phys_reg_tag       = rob_safe[kill_read_index];
    assign kill_read_speculated_phys_reg_tag = rob_spec[kill_read_index];

    always #5 CLK = ~CLK;

    rob_rollback_ctrl #(.ROB_DEPTH(16), .INDEX_W(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .rob_head_index(rob_head_index), .rob_tail_index(rob_tail_index), .rob_count(rob_count),
        .BRU_restart_valid(BRU_restart_valid), .BRU_restart_ROB_index(BRU_restart_ROB_index),
        .BRU_restart_PC(BRU_restart_PC), .BRU_restart_safe_column(BRU_restart_safe_column),
        .LQ_restart_valid(LQ_restart_valid), .LQ_restart_ROB_index(LQ_restart_ROB_index),
        .LQ_restart_PC(LQ_restart_PC),
        .restore_checkpoint_valid(restore_checkpoint_valid),
        .restore_checkpoint_speculate_failed(restore_checkpoint_speculate_failed),
        .restore_checkpoint_ROB_index(restore_checkpoint_ROB_index),
        .restore_checkpoint_safe_column(restore_checkpoint_safe_column),
        .restore_checkpoint_success(restore_checkpoint_success),
        .kill_read_index(kill_read_index), .kill_read_writes_reg(kill_read_writes_reg),
        .kill_read_arch_reg_tag(kill_read_arch_reg_tag),
        .kill_read_safe_phys_reg_tag(kill_read_safe_phys_reg_tag),
        .kill_read_speculated_phys_reg_tag(kill_read_speculated_phys_reg_tag),
        .kill_bus_valid(kill_bus_valid), .kill_bus_ROB_index(kill_bus_ROB_index),
        .kill_bus_arch_reg_tag(kill_bus_arch_reg_tag),
        .kill_bus_safe_phys_reg_tag(kill_bus_safe_phys_reg_tag),
        .kill_bus_speculated_phys_reg_tag(kill_bus_speculated_phys_reg_tag),
        .rob_tail_restore_valid(rob_tail_restore_valid), .rob_tail_restore_index(rob_tail_restore_index),
        .fetch_restart_valid(fetch_restart_valid), .fetch_restart_PC(fetch_restart_PC),
        .core_control_restore_flush(core_control_restore_flush),
        .core_control_kill_stall(core_control_kill_stall), .busy(busy)
    );

    typedef struct packed {
        logic        rv;
        logic        rsf;
        logic [3:0]  ridx;
        logic [1:0]  rcol;
        logic [3:0]  kri;
        logic        kv;
        logic [3:0]  kidx;
        logic [4:0]  karch;
        logic [5:0]  ksafe;
        logic [5:0]  kspec;
        logic        tv;
        logic [3:0]  tidx;
        logic        fv;
        logic [31:0] fpc;
        logic        fl;
        logic        st;
        logic        bz;
    } obs_t;

    typedef struct {
        int head;
        int tail;
        bit bv;
        int bidx;
        bit lv;
        int lidx;
        bit succ;
    } txn_in_t;

    typedef struct {
        txn_in_t in;
        bit      e_bru;
        int      e_bidx;
        int      e_nkill;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    function automatic obs_t sample();
        obs_t o;
        o.rv    = restore_checkpoint_valid;
        o.rsf   = restore_checkpoint_speculate_failed;
        o.ridx  = restore_checkpoint_ROB_index;
        o.rcol  = restore_checkpoint_safe_column;
        o.kri   = kill_read_index;
        o.kv    = kill_bus_valid;
        o.kidx  = kill_bus_ROB_index;
        o.karch = kill_bus_arch_reg_tag;
        o.ksafe = kill_bus_safe_phys_reg_tag;
        o.kspec = kill_bus_speculated_phys_reg_tag;
        o.tv    = rob_tail_restore_valid;
        o.tidx  = rob_tail_restore_index;
        o.fv    = fetch_restart_valid;
        o.fpc   = fetch_restart_PC;
        o.fl    = core_control_restore_flush;
        o.st    = core_control_kill_stall;
        o.bz    = busy;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: outputs actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic no_req();
        BRU_restart_valid = 1'b0;
        LQ_restart_valid  = 1'b0;
    endtask

    task automatic fill_rob(input bit alternate, input int phase);
        for (int i = 0; i < 16; i++) begin
            rob_wr[i]   = alternate ? 1'((i + phase) % 2) : 1'($urandom_range(0, 3) != 0);
            rob_arch[i] = 5'($urandom);
            rob_safe[i] = 6'($urandom);
            rob_spec[i] = 6'($urandom);
        end
    endtask

    // Reference: derive the whole output trace of one idle-to-idle recovery from the rules.
    task automatic run_txn(input txn_in_t t, input logic [31:0] bpc, input logic [31:0] lpc,
                           input logic [1:0] bcol, input string tag,
                           output bit o_bru, output int o_bidx, output int o_nkill);
        obs_t e;
        obs_t expq[$];
        obs_t act;
        int count, bru_age, lq_age, bage, bidx, nkill, p;
        bit is_bru;
        count   = (t.tail - t.head + 16) % 16;
        bru_age = ((t.bidx - t.head + 16) % 16) + 1;
        lq_age  = (t.lidx - t.head + 16) % 16;
        is_bru  = t.bv && (!t.lv || bru_age <= lq_age);
        bage    = is_bru ? bru_age : lq_age;
        bidx    = is_bru ? (t.bidx + 1) % 16 : t.lidx;
        e = '0; e.fl = 1'b1; expq.push_back(e);
        if (is_bru) begin
            e = '0; e.rv = 1'b1; e.rsf = 1'b1; e.ridx = 4'(t.bidx); e.rcol = bcol;
            e.st = 1'b1; e.bz = 1'b1; expq.push_back(e);
        end
        nkill = ((!is_bru || !t.succ) && bage < count) ? count - bage : 0;
        for (int k = 0; k < nkill; k++) begin
            p = (t.tail - 1 - k + 32) % 16;
            e = '0; e.kri = 4'(p); e.kv = rob_wr[p]; e.kidx = 4'(p);
            e.karch = rob_arch[p]; e.ksafe = rob_safe[p]; e.kspec = rob_spec[p];
            e.st = 1'b1; e.bz = 1'b1; expq.push_back(e);
        end
        e = '0; e.fv = 1'b1; e.fpc = is_bru ? bpc : lpc; e.tv = 1'b1; e.tidx = 4'(bidx);
        e.st = 1'b1; e.bz = 1'b1; expq.push_back(e);
        e = '0; expq.push_back(e);

        o_bru = 1'b0; o_bidx = -1; o_nkill = 0;
        foreach (expq[i]) begin
            @(negedge CLK);
            rob_head_index = 4'(t.head);
            rob_tail_index = 4'(t.tail);
            rob_count      = 5'(count);
            restore_checkpoint_success = t.succ;
            if (i == 0) begin
                BRU_restart_valid = t.bv; BRU_restart_ROB_index = 4'(t.bidx);
                BRU_restart_PC = bpc; BRU_restart_safe_column = bcol;
                LQ_restart_valid = t.lv; LQ_restart_ROB_index = 4'(t.lidx); LQ_restart_PC = lpc;
            end else begin
                no_req();
            end
            #1;
            check_obs($sformatf("%s_cyc%0d", tag, i), expq[i]);
            act = sample();
            if (act.rv) o_bru = 1'b1;
            if (act.tv) o_bidx = int'(act.tidx);
            if (act.st && !act.rv && !act.tv) o_nkill++;
        end
    endtask

    vec_t vecs[7];

    initial begin
        obs_t z;
        bit   o_bru;
        int   o_bidx, o_nkill;
        int   kq[$];
        int   exp_k[$];
        bit   got_redirect;
        int   red_pc, red_idx;
        txn_in_t t;
        z = '0;

        vecs[0] = '{'{2, 8, 1, 4, 0, 0, 1}, 1, 5, 0};
        vecs[1] = '{'{2, 8, 1, 4, 0, 0, 0}, 1, 5, 3};
        vecs[2] = '{'{14, 2, 0, 0, 1, 15, 0}, 0, 15, 3};
        vecs[3] = '{'{0, 10, 1, 6, 1, 3, 1}, 0, 3, 7};
        vecs[4] = '{'{0, 10, 1, 6, 1, 7, 0}, 1, 7, 3};
        vecs[5] = '{'{0, 5, 1, 4, 0, 0, 0}, 1, 5, 0};
        vecs[6] = '{'{12, 3, 1, 15, 0, 0, 0}, 1, 0, 3};

        nRST = 1'b1;
        no_req();
        rob_head_index = '0; rob_tail_index = '0; rob_count = '0;
        BRU_restart_ROB_index = '0; BRU_restart_PC = '0; BRU_restart_safe_column = '0;
        LQ_restart_ROB_index = '0; LQ_restart_PC = '0; restore_checkpoint_success = 1'b0;
        fill_rob(1'b1, 0);
        repeat (3) @(negedge CLK);
        #1 check_obs("reset_hold", z);
        @(negedge CLK);
        nRST = 1'b0;
        #1 check_obs("reset_release", z);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            fill_rob(1'b1, i);
            run_txn(vecs[i].in, 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i), 2'(i),
                    $sformatf("vec%0d", i), o_bru, o_bidx, o_nkill);
            check_val($sformatf("vec%0d_restore_issued", i), int'(o_bru), int'(vecs[i].e_bru));
            check_val($sformatf("vec%0d_tail_restore", i), o_bidx, vecs[i].e_bidx);
            check_val($sformatf("vec%0d_kill_cycles", i), o_nkill, vecs[i].e_nkill);
        end

        // Preemption: walk toward boundary 6 is extended by an older LQ restart at 2
        fill_rob(1'b0, 0);
        @(negedge CLK);
        rob_head_index = 4'd0; rob_tail_index = 4'd10; rob_count = 5'd10;
        LQ_restart_valid = 1'b1; LQ_restart_ROB_index = 4'd6; LQ_restart_PC = 32'h0000_6600;
        #1 check_val("pre_accept_flush", int'(core_control_restore_flush), 1);
        got_redirect = 1'b0; red_pc = 0; red_idx = -1;
        for (int c = 0; c < 30 && !got_redirect; c++) begin
            @(negedge CLK);
            no_req();
            if (c == 1) begin
                LQ_restart_valid = 1'b1; LQ_restart_ROB_index = 4'd2; LQ_restart_PC = 32'h0000_2200;
            end else if (c == 4) begin
                LQ_restart_valid = 1'b1; LQ_restart_ROB_index = 4'd8; LQ_restart_PC = 32'h0000_8800;
            end
            #1;
            if (c == 1) check_val("pre_no_flush_when_busy", int'(core_control_restore_flush), 0);
            if (fetch_restart_valid) begin
                got_redirect = 1'b1;
                red_pc  = int'(fetch_restart_PC);
                red_idx = int'(rob_tail_restore_index);
            end else if (core_control_kill_stall) begin
                kq.push_back(int'(kill_read_index));
            end
        end
        no_req();
        check_val("pre_redirect_seen", int'(got_redirect), 1);
        check_val("pre_redirect_pc", red_pc, 32'h0000_2200);
        check_val("pre_tail_restore", red_idx, 2);
        for (int k = 9; k >= 2; k--) exp_k.push_back(k);
        check_val("pre_kill_count", kq.size(), exp_k.size());
        for (int k = 0; k < exp_k.size() && k < kq.size(); k++)
            check_val($sformatf("pre_kill_idx%0d", k), kq[k], exp_k[k]);
        @(negedge CLK);
        #1 check_obs("pre_back_idle", z);

        // Reset in the middle of a walk abandons it without a redirect
        @(negedge CLK);
        rob_head_index = 4'd0; rob_tail_index = 4'd10; rob_count = 5'd10;
        LQ_restart_valid = 1'b1; LQ_restart_ROB_index = 4'd3; LQ_restart_PC = 32'h0000_3300;
        repeat (2) begin
            @(negedge CLK);
            no_req();
        end
        #1 check_val("rst_walk_in_progress", int'(core_control_kill_stall), 1);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1 check_obs("rst_during_reset", z);
        @(negedge CLK);
        nRST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check_obs($sformatf("rst_after_cyc%0d", c), z);
            @(negedge CLK);
        end

        // Randomized recoveries against the reference model
        for (int n = 0; n < 200; n++) begin
            fill_rob(1'b0, 0);
            t.head = int'($urandom_range(0, 15));
            t.tail = (t.head + int'($urandom_range(0, 15))) % 16;
            t.bv   = 1'($urandom);
            t.lv   = t.bv ? 1'($urandom) : 1'b1;
            t.bidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                     : (t.head + int'($urandom_range(0, 15))) % 16;
            t.lidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                     : (t.head + int'($urandom_range(0, 15))) % 16;
            t.succ = 1'($urandom);
            run_txn(t, $urandom, $urandom, 2'($urandom), $sformatf("rnd%0d", n),
                    o_bru, o_bidx, o_nkill);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
